bram_rd_arbiter: RTL and testbench

Controller that owns one simple dual-port `bram` instance and shares its read port among NREQ neuron-core requesters with round-robin arbitration. A single loader channel drives the write port. After every reset the block sweeps the memory to zero before it accepts traffic. It sits between the weight loader and the neuron cores in the weight-memory path, so the cores never drive `bram` directly.

---
 rtl/bram_rd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bram_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_arbiter.sv
// Weight-memory read arbiter: round-robin sharing of one bram read port among NREQ cores, zero sweep after reset.
// Optional same-cycle write-to-read forwarding is built when BRAM_ARB_FWD_EN is defined.

module bram #(
  parameter int ADDR  = 10,
  parameter int WIDE  = 8,
  parameter int DEPTH = 1024
) (
  input  logic            clka,
  input  logic            wea,
  input  logic [ADDR-1:0] addra,
  input  logic [WIDE-1:0] dina,
  input  logic            clkb,
  input  logic [ADDR-1:0] addrb,
  output logic [WIDE-1:0] doutb
);
  logic [WIDE-1:0] mem_q [DEPTH];

  always_ff @(posedge clka) begin
    if (wea) mem_q[addra] <= dina;
  end

  // Read-first: a same-edge write is not visible on doutb until the next read.
  always_ff @(posedge clkb) begin
    doutb <= mem_q[addrb];
  end
endmodule

module bram_rd_arbiter #(
  parameter int ADDR  = 10,
  parameter int WIDE  = 8,
  parameter int DEPTH = 1024,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR-1:0]      wr_addr,
  input  logic [WIDE-1:0]      wr_data,
  input  logic [NREQ-1:0]      rd_req,
  input  logic [NREQ*ADDR-1:0] rd_addr,
  output logic [NREQ-1:0]      rd_gnt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [WIDE-1:0]      rsp_data,
  output logic                 init_done
);
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic            rsp_vld_q;
  logic [IDW-1:0]  rsp_id_q;

  logic            run;
  logic            wr_acc;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic [ADDR-1:0] addr_arr [NREQ];
  logic [ADDR-1:0] rd_addrb;
  logic            bram_we;
  logic [ADDR-1:0] bram_addra;
  logic [WIDE-1:0] bram_dina;
  logic [WIDE-1:0] doutb;

  assign run    = (state_q == S_RUN);
  assign wr_acc = run & wr_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + ADDR'(1);
      if (cnt_q == ADDR'(DEPTH - 1)) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) addr_arr[i] = rd_addr[i*ADDR +: ADDR];
  end

  // Scan starts one past the last winner so a held request waits at most NREQ-1 cycles.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (run) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDW'((int'(last_q) + k) % NREQ);
        if (!gnt_any && rd_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign last_d   = gnt_any ? gnt_idx : last_q;
  assign rd_gnt   = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign rd_addrb = addr_arr[gnt_idx];

  // The sweep owns the write port until RUN.
  assign bram_we    = run ? wr_acc  : 1'b1;
  assign bram_addra = run ? wr_addr : cnt_q;
  assign bram_dina  = run ? wr_data : '0;

  bram #(.ADDR(ADDR), .WIDE(WIDE), .DEPTH(DEPTH)) u_bram (
    .clka  (clk),
    .wea   (bram_we),
    .addra (bram_addra),
    .dina  (bram_dina),
    .clkb  (clk),
    .addrb (rd_addrb),
    .doutb (doutb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      last_q    <= IDW'(NREQ - 1);
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rsp_vld_q <= gnt_any;
      if (gnt_any) rsp_id_q <= gnt_idx;
    end
  end

`ifdef BRAM_ARB_FWD_EN
  logic            fwd_q;
  logic [WIDE-1:0] fwd_dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_q     <= 1'b0;
      fwd_dat_q <= '0;
    end else begin
      fwd_q     <= wr_acc & gnt_any & (wr_addr == rd_addrb);
      fwd_dat_q <= wr_data;
    end
  end

  assign rsp_data = rsp_vld_q ? (fwd_q ? fwd_dat_q : doutb) : '0;
`else
  assign rsp_data = rsp_vld_q ? doutb : '0;
`endif

  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign wr_ready  = run;
  assign init_done = run;
endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Randomized and directed bench for bram_rd_arbiter against a memory-array / round-robin reference model.
module tb_bram_rd_arbiter;
  localparam int ADDR  = 10;
  localparam int WIDE  = 8;
  localparam int DEPTH = 1024;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic [ADDR-1:0]      wr_addr = '0;
  logic [WIDE-1:0]      wr_data = '0;
  logic [NREQ-1:0]      rd_req = '0;
  logic [NREQ*ADDR-1:0] rd_addr = '0;
  logic [NREQ-1:0]      rd_gnt;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [WIDE-1:0]      rsp_data;
  logic                 init_done;

  always #5 clk = ~clk;

  bram_rd_arbiter #(.ADDR(ADDR), .WIDE(WIDE), .DEPTH(DEPTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .init_done (init_done)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic [ADDR-1:0] a [NREQ];
  logic [NREQ-1:0] req = '0;

  // Reference model
  logic [WIDE-1:0] mem [DEPTH];
  bit              run;
  int              init_left;
  int              last;
  bit              exp_vld;
  int              exp_id;
  logic [WIDE-1:0] exp_dat;
  int              g_last;
  int              on [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check at negedge, advance the model, return just after posedge.
  task automatic tick();
    int win, best, d;
    logic [ADDR-1:0] ra;
    rd_req  = req;
    rd_addr = {a[3], a[2], a[1], a[0]};
    @(negedge clk);
    win  = -1;
    best = NREQ;
    if (run) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          d = (i - last - 1 + 2 * NREQ) % NREQ;
          if (d < best) begin
            best = d;
            win  = i;
          end
        end
      end
    end
    chk("rd_gnt", 32'(rd_gnt), (win >= 0) ? (32'(1) << win) : 32'(0));
    chk("init_done", 32'(init_done), 32'(run));
    chk("wr_ready", 32'(wr_ready), 32'(run));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    chk("rsp_data", 32'(rsp_data), exp_vld ? 32'(exp_dat) : 32'(0));
    if (exp_vld) chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    g_last = win;
    if (win >= 0) begin
      ra      = a[win];
      exp_dat = mem[ra];
`ifdef BRAM_ARB_FWD_EN
      if (wr_valid && wr_addr == ra) exp_dat = wr_data;
`endif
      last    = win;
      exp_vld = 1'b1;
      exp_id  = win;
    end else begin
      exp_vld = 1'b0;
    end
    if (run && wr_valid) mem[wr_addr] = wr_data;
    if (!run) begin
      init_left--;
      if (init_left == 0) begin
        run = 1'b1;
        for (int j = 0; j < DEPTH; j++) mem[j] = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    run       = 1'b0;
    init_left = DEPTH;
    exp_vld   = 1'b0;
    exp_id    = 0;
    last      = NREQ - 1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_wr_ready", 32'(wr_ready), 32'(0));
    chk("rst_rd_gnt", 32'(rd_gnt), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    req = NREQ'($urandom_range(0, 15));
    for (int i = 0; i < NREQ; i++) a[i] = ADDR'($urandom_range(0, DEPTH - 1));
    wr_valid = 1'($urandom_range(0, 1));
    wr_addr  = ADDR'($urandom_range(0, DEPTH - 1));
    wr_data  = WIDE'($urandom_range(0, 255));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a[i]  = '0;
      on[i] = 0;
    end
    req = '1;
    do_reset();

    // Sweep with noise on every input: nothing may be granted or accepted.
    for (int k = 0; k < DEPTH; k++) begin
      rand_inputs();
      tick();
    end

    // All requesters from the first RUN cycle; fresh memory reads as zero.
    req = '1;
    wr_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) a[i] = ADDR'($urandom_range(0, DEPTH - 1));
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_order", 32'(g_last), 32'(k % NREQ));
    end
    req = '0;
    tick();

    // Write then read back through requester 2.
    wr_valid = 1'b1; wr_addr = 10'd3; wr_data = 8'h5A;
    tick();
    wr_valid = 1'b0;
    req = 4'b0100; a[2] = 10'd3;
    tick();
    chk("rd5a_data", 32'(rsp_data), 32'h5A);
    chk("rd5a_id", 32'(rsp_id), 32'd2);
    req = '0;
    tick();

    // Same-address write and read in one cycle.
    wr_valid = 1'b1; wr_addr = 10'd7; wr_data = 8'h33;
    req = 4'b0001; a[0] = 10'd7;
    tick();
`ifdef BRAM_ARB_FWD_EN
    chk("collision", 32'(rsp_data), 32'h33);
`else
    chk("collision", 32'(rsp_data), 32'h00);
`endif
    wr_valid = 1'b0; req = '0;
    tick();

    // Requester 1 alone, then requester 3 joins.
    req = 4'b0010; a[1] = 10'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("solo_r1", 32'(g_last), 32'd1);
    end
    req = 4'b1010; a[3] = 10'd7;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("alt_1_3", 32'(g_last), (k % 2 == 0) ? 32'd3 : 32'd1);
    end
    req = '0;
    tick();

    // Random traffic over a small address window, requesters hold until granted.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (on[i] == 0 && $urandom_range(0, 2) == 0) begin
          on[i] = 1;
          a[i]  = ADDR'($urandom_range(0, 15));
        end
        req[i] = (on[i] != 0);
      end
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = ADDR'($urandom_range(0, 15));
      wr_data  = WIDE'($urandom_range(0, 255));
      tick();
      if (g_last >= 0) begin
        on[g_last] = int'($urandom_range(0, 1));
        if (on[g_last] != 0) a[g_last] = ADDR'($urandom_range(0, 15));
      end
    end
    req = '0; wr_valid = 1'b0;
    tick();

    // Reset with a response in flight, then confirm the sweep cleared prior writes.
    wr_valid = 1'b1; wr_addr = 10'd9; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    req = 4'b0001; a[0] = 10'd9;
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    do_reset();
    req = '1;
    for (int k = 0; k < DEPTH; k++) tick();
    req = 4'b0111; a[0] = 10'd3; a[1] = 10'd7; a[2] = 10'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_valid", 32'(rsp_valid), 32'd1);
      chk("post_rst_zero", 32'(rsp_data), 32'd0);
      req[g_last] = 1'b0;
    end
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
